// File: rtl/vx_schedule_buffer_if.sv
// Schedule->fetch buffer bus: per-lane valid/ready in and out, warp flush, occupancy.
// perf_stalls exists only when VX_SCHED_BUF_PERF_EN is defined.
interface vx_schedule_buffer_if #(
  parameter int SCHEDULE_WIDTH = 1,
  parameter int DATAW          = 39,
  parameter int NW_W           = 2,
  parameter int CNTW           = 2
);
  logic [SCHEDULE_WIDTH-1:0]       in_valid;
  logic [SCHEDULE_WIDTH*DATAW-1:0] in_data;
  logic [SCHEDULE_WIDTH-1:0]       in_ready;
  logic [SCHEDULE_WIDTH-1:0]       out_valid;
  logic [SCHEDULE_WIDTH*DATAW-1:0] out_data;
  logic [SCHEDULE_WIDTH-1:0]       out_ready;
  logic                            flush_valid;
  logic [NW_W-1:0]                 flush_wid;
  logic [SCHEDULE_WIDTH*CNTW-1:0]  occupancy;
`ifdef VX_SCHED_BUF_PERF_EN
  logic [SCHEDULE_WIDTH*32-1:0]    perf_stalls;
`endif

  modport master (
    output in_valid, in_data, out_ready, flush_valid, flush_wid,
`ifdef VX_SCHED_BUF_PERF_EN
    input  perf_stalls,
`endif
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush_valid, flush_wid,
`ifdef VX_SCHED_BUF_PERF_EN
    output perf_stalls,
`endif
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/vx_schedule_buffer.sv
// Per-lane DEPTH-entry elastic buffer with per-warp flush; 1-cycle latency, no bypass, in_ready from registered state only.
// Define VX_SCHED_BUF_PERF_EN to add saturating per-lane stall counters on perf_stalls.
module vx_schedule_buffer #(
  parameter int SCHEDULE_WIDTH = 1,
  parameter int DEPTH          = 2,
  parameter int UUID_W         = 1,
  parameter int NW_W           = 2,
  parameter int NT             = 4,
  parameter int XLEN           = 32,
  parameter int DATAW          = UUID_W + NW_W + NT + XLEN,
  parameter int CNTW           = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  vx_schedule_buffer_if.slave bus
);
  localparam int              AW       = $clog2(DEPTH);
  localparam int              WID_LSB  = NT + XLEN;
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  for (genvar g = 0; g < SCHEDULE_WIDTH; g++) begin : g_lane
    logic [DATAW-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             rdy_q, rdy_d;
    logic [DATAW-1:0] in_dat;
    logic             nonempty, live_head, push, pop, drop, deq;

    assign in_dat    = bus.in_data[g*DATAW +: DATAW];
    assign nonempty  = (count_q != '0);
    assign live_head = nonempty && !kill_q[rd_ptr_q];
    assign push      = bus.in_valid[g] && rdy_q;
    assign pop       = live_head && bus.out_ready[g];
    // A killed head retires on its own, independent of the consumer.
    assign drop      = nonempty && kill_q[rd_ptr_q];
    assign deq       = pop || drop;

    always_comb begin
      kill_d = kill_q;
      if (bus.flush_valid) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (mem_q[j][WID_LSB +: NW_W] == bus.flush_wid) kill_d[j] = 1'b1;
        end
      end
      // The incoming entry must also see a same-cycle flush.
      if (push) begin
        kill_d[wr_ptr_q] = bus.flush_valid && (in_dat[WID_LSB +: NW_W] == bus.flush_wid);
      end
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = deq  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      if (push && !deq)      count_d = count_q + CNT_ONE;
      else if (!push && deq) count_d = count_q - CNT_ONE;
      rdy_d = (count_d != CNT_FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        kill_q   <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        rdy_q    <= 1'b0;
      end else begin
        kill_q   <= kill_d;
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        rdy_q    <= rdy_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_dat;
    end

    assign bus.in_ready[g]                = rdy_q;
    assign bus.out_valid[g]               = live_head;
    assign bus.out_data[g*DATAW +: DATAW] = mem_q[rd_ptr_q];
    assign bus.occupancy[g*CNTW +: CNTW]  = count_q;

`ifdef VX_SCHED_BUF_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stall_q <= '0;
      end else if (bus.in_valid[g] && !rdy_q && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end

    assign bus.perf_stalls[g*32 +: 32] = stall_q;
`endif
  end
endmodule

// File: tb/tb_vx_schedule_buffer.sv
// Directed bench: DUT A (2 lanes, DEPTH 2) for latency/order/full/reset, DUT B (2 lanes, DEPTH 4) for flush.
module tb_vx_schedule_buffer;
  localparam int SW  = 2;
  localparam int DW  = 39;
  localparam int CWA = 2;
  localparam int CWB = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vx_schedule_buffer_if #(.SCHEDULE_WIDTH(SW), .DATAW(DW), .NW_W(2), .CNTW(CWA)) ia ();
  vx_schedule_buffer_if #(.SCHEDULE_WIDTH(SW), .DATAW(DW), .NW_W(2), .CNTW(CWB)) ib ();

  vx_schedule_buffer #(.SCHEDULE_WIDTH(SW), .DEPTH(2)) u_dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
  vx_schedule_buffer #(.SCHEDULE_WIDTH(SW), .DEPTH(4)) u_dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));

  int n_checks = 0;
  int n_pass   = 0;
  // Scoreboard queues: 0,1 = DUT A lanes; 2,3 = DUT B lanes.
  logic [DW-1:0] sbq [4][$];

  function automatic logic [DW-1:0] mk(input logic uuid, input logic [1:0] wid,
                                       input logic [3:0] tm, input logic [31:0] pc);
    return {uuid, wid, tm, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  // Reference behaviour of one lane for the coming edge: deliver head, apply flush, accept push.
  task automatic sb_lane(input int id, input logic iv, input logic ir, input logic ov, input logic ordy,
                         input logic [DW-1:0] idat, input logic [DW-1:0] odat,
                         input logic fv, input logic [1:0] fw);
    logic [DW-1:0] e;
    if (ov && ordy) begin
      if (sbq[id].size() == 0) begin
        chk($sformatf("pop_extra_q%0d", id), 64'(ov), 64'd0);
      end else begin
        e = sbq[id].pop_front();
        chk($sformatf("pop_data_q%0d", id), 64'(odat), 64'(e));
      end
    end
    if (fv) begin
      for (int k = sbq[id].size() - 1; k >= 0; k--) begin
        if (sbq[id][k][37:36] == fw) sbq[id].delete(k);
      end
    end
    if (iv && ir && !(fv && idat[37:36] == fw)) sbq[id].push_back(idat);
  endtask

  task automatic tick();
    #1;
    for (int l = 0; l < SW; l++) begin
      sb_lane(l, ia.in_valid[l], ia.in_ready[l], ia.out_valid[l], ia.out_ready[l],
              ia.in_data[l*DW +: DW], ia.out_data[l*DW +: DW], ia.flush_valid, ia.flush_wid);
      sb_lane(SW + l, ib.in_valid[l], ib.in_ready[l], ib.out_valid[l], ib.out_ready[l],
              ib.in_data[l*DW +: DW], ib.out_data[l*DW +: DW], ib.flush_valid, ib.flush_wid);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n        = 1'b0;
    ia.in_valid    = '0; ia.in_data = '0; ia.out_ready = '0; ia.flush_valid = 1'b0; ia.flush_wid = '0;
    ib.in_valid    = '0; ib.in_data = '0; ib.out_ready = '0; ib.flush_valid = 1'b0; ib.flush_wid = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
    chk("rst_in_ready",  64'(ia.in_ready),  64'd0);
    chk("rst_occupancy", 64'(ia.occupancy), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_in_ready", 64'(ia.in_ready), 64'h3);

    // Latency and order on lane 0
    ia.in_data[0 +: DW] = mk(1'b0, 2'd0, 4'hf, 32'h100);
    ia.in_valid = 2'b01;
    tick();
    chk("lat_out_valid", 64'(ia.out_valid), 64'h1);
    chk("lat_out_data",  64'(ia.out_data[0 +: DW]), 64'(mk(1'b0, 2'd0, 4'hf, 32'h100)));
    ia.in_data[0 +: DW] = mk(1'b0, 2'd0, 4'hf, 32'h104);
    tick();
    chk("two_occ_l0",    64'(ia.occupancy[1:0]), 64'd2);
    chk("two_in_ready",  64'(ia.in_ready), 64'h2);
    chk("l1_out_valid",  64'(ia.out_valid[1]), 64'd0);

    // Full stall with in_valid held for 5 cycles
    ia.in_data[0 +: DW] = mk(1'b0, 2'd0, 4'hf, 32'h108);
    repeat (5) tick();
    chk("full_in_ready", 64'(ia.in_ready[0]), 64'd0);
    chk("full_occ",      64'(ia.occupancy[1:0]), 64'd2);
    chk("full_hold",     64'(ia.out_data[0 +: DW]), 64'(mk(1'b0, 2'd0, 4'hf, 32'h100)));
`ifdef VX_SCHED_BUF_PERF_EN
    chk("perf_l0", 64'(ia.perf_stalls[31:0]),  64'd5);
    chk("perf_l1", 64'(ia.perf_stalls[63:32]), 64'd0);
`endif
    ia.out_ready = 2'b01;
    tick();
    chk("freed_in_ready", 64'(ia.in_ready[0]), 64'd1);
    chk("freed_no_push",  64'(ia.occupancy[1:0]), 64'd1);
    ia.out_ready = 2'b00;
    tick();
    chk("refill_occ", 64'(ia.occupancy[1:0]), 64'd2);
    ia.in_valid  = 2'b00;
    ia.out_ready = 2'b01;
    repeat (2) tick();
    chk("drain_out_valid", 64'(ia.out_valid), 64'd0);
    chk("drain_occ",       64'(ia.occupancy), 64'd0);
    chk("drain_sb_l0",     64'(sbq[0].size()), 64'd0);

    // Lane 1: back-to-back push+pop wraps the pointers
    ia.in_valid  = 2'b10;
    ia.out_ready = 2'b10;
    for (int i = 0; i < 6; i++) begin
      ia.in_data[DW +: DW] = mk(1'b1, 2'(i), 4'h3, 32'(32'h200 + 4 * i));
      tick();
    end
    chk("wrap_occ_l1",   64'(ia.occupancy[3:2]), 64'd1);
    chk("wrap_valid_l1", 64'(ia.out_valid), 64'h2);
    ia.in_valid = 2'b00;
    tick();
    chk("wrap_sb_l1",  64'(sbq[1].size()), 64'd0);
    chk("wrap_empty",  64'(ia.out_valid), 64'd0);

    // Reset while two entries are stored
    ia.out_ready = 2'b00;
    ia.in_valid  = 2'b01;
    ia.in_data[0 +: DW] = mk(1'b0, 2'd1, 4'hf, 32'h600);
    tick();
    ia.in_data[0 +: DW] = mk(1'b0, 2'd1, 4'hf, 32'h604);
    tick();
    ia.in_valid = 2'b00;
    chk("mid_occ_before", 64'(ia.occupancy[1:0]), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(ia.out_valid), 64'd0);
    chk("mid_rst_occ",       64'(ia.occupancy), 64'd0);
    chk("mid_rst_in_ready",  64'(ia.in_ready),  64'd0);
    for (int q = 0; q < 4; q++) sbq[q].delete();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rel_in_ready",  64'(ia.in_ready),  64'h3);
    chk("mid_rel_out_valid", 64'(ia.out_valid), 64'd0);

    // Flush: lane 0 holds wids {1,2,1}, lane 1 holds {1,0}
    ib.out_ready = 2'b00;
    ib.in_valid  = 2'b11;
    ib.in_data[0 +: DW]  = mk(1'b0, 2'd1, 4'h1, 32'h300);
    ib.in_data[DW +: DW] = mk(1'b1, 2'd1, 4'h2, 32'h400);
    tick();
    ib.in_data[0 +: DW]  = mk(1'b0, 2'd2, 4'h1, 32'h304);
    ib.in_data[DW +: DW] = mk(1'b1, 2'd0, 4'h2, 32'h404);
    tick();
    ib.in_valid = 2'b01;
    ib.in_data[0 +: DW]  = mk(1'b0, 2'd1, 4'h1, 32'h308);
    tick();
    ib.in_valid = 2'b00;
    chk("fl_occ_l0_pre", 64'(ib.occupancy[2:0]), 64'd3);
    chk("fl_occ_l1_pre", 64'(ib.occupancy[5:3]), 64'd2);
    chk("fl_valid_pre",  64'(ib.out_valid), 64'h3);
    ib.flush_valid = 1'b1;
    ib.flush_wid   = 2'd1;
    tick();
    ib.flush_valid = 1'b0;
    chk("fl_valid_t1", 64'(ib.out_valid), 64'd0);
    chk("fl_occ_3",    64'(ib.occupancy[2:0]), 64'd3);
    ib.out_ready = 2'b11;
    tick();
    chk("fl_occ_2",    64'(ib.occupancy[2:0]), 64'd2);
    chk("fl_valid_t2", 64'(ib.out_valid), 64'h3);
    tick();
    chk("fl_occ_1",    64'(ib.occupancy[2:0]), 64'd1);
    chk("fl_valid_t3", 64'(ib.out_valid), 64'd0);
    tick();
    chk("fl_occ_0",    64'(ib.occupancy), 64'd0);
    chk("fl_sb_l0",    64'(sbq[2].size()), 64'd0);
    chk("fl_sb_l1",    64'(sbq[3].size()), 64'd0);

    // Flush and matching push in the same cycle
    ib.out_ready   = 2'b01;
    ib.in_valid    = 2'b01;
    ib.in_data[0 +: DW] = mk(1'b0, 2'd3, 4'h1, 32'h500);
    ib.flush_valid = 1'b1;
    ib.flush_wid   = 2'd3;
    chk("col_in_ready", 64'(ib.in_ready[0]), 64'd1);
    tick();
    ib.in_valid    = 2'b00;
    ib.flush_valid = 1'b0;
    chk("col_occ_1",   64'(ib.occupancy[2:0]), 64'd1);
    chk("col_valid",   64'(ib.out_valid[0]), 64'd0);
    tick();
    chk("col_occ_0",   64'(ib.occupancy[2:0]), 64'd0);
    ib.in_valid = 2'b01;
    ib.in_data[0 +: DW] = mk(1'b1, 2'd3, 4'h1, 32'h504);
    tick();
    ib.in_valid = 2'b00;
    chk("post_valid",  64'(ib.out_valid), 64'h1);
    tick();
    chk("post_sb_l0",  64'(sbq[2].size()), 64'd0);
    chk("post_empty",  64'(ib.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
